// File: rtl/riscv_mt_aligner_pkg.sv
// Aligner additions to riscv_defines: hart count, slot state enum, slot struct and
// the compressed-halfword test shared by the aligner files.
package riscv_defines;

  localparam int NUM_THREADS       = 4;
  localparam int THREAD_ADDR_WIDTH = $clog2(NUM_THREADS);

  localparam logic [1:0] OPCODE_C_MASK = 2'b11;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    RESID_C = 2'd1,
    PARTIAL = 2'd2
  } aligner_state_e;

  typedef struct packed {
    aligner_state_e state;
    logic [15:0]    resid;
    logic [31:0]    rpc;
  } aligner_slot_t;

  // A halfword is a full 32-bit opcode only when both low bits are set.
  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw[1:0] & OPCODE_C_MASK) != OPCODE_C_MASK;
  endfunction

endpackage

// File: rtl/riscv_mt_aligner_slot.sv
// One hart's leftover-halfword slot: decides what the current fetch word emits for
// this hart and whether the word is consumed; the slot only moves when sel/flush say so.
import riscv_defines::*;

module riscv_mt_aligner_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        flush,
  input  logic [31:0] fetch_rdata,
  input  logic [31:1] fetch_addr,
  output logic        emit_valid,
  output logic [31:0] emit_rdata,
  output logic [31:0] emit_pc,
  output logic        emit_compressed,
  output logic        consume
);

  aligner_slot_t slot_q;
  aligner_slot_t slot_d;

  logic [15:0] lo_hw;
  logic [15:0] hi_hw;
  logic [31:0] word_pc;
  logic [31:0] hi_pc;
  logic [31:0] next_pc;
  logic        match_resid;
  logic        match_partial;

  assign lo_hw   = fetch_rdata[15:0];
  assign hi_hw   = fetch_rdata[31:16];
  assign word_pc = {fetch_addr[31:2], 2'b00};
  assign hi_pc   = {fetch_addr[31:2], 2'b10};
  assign next_pc = slot_q.rpc + 32'd2;

  // A residue is only useful when the fetch continues exactly where it left off.
  assign match_resid   = (slot_q.state == RESID_C) && ({fetch_addr, 1'b0} == next_pc);
  assign match_partial = (slot_q.state == PARTIAL) &&
                         ({fetch_addr, 1'b0} == {next_pc[31:2], 2'b00});

  always_comb begin
    slot_d          = slot_q;
    emit_valid      = 1'b0;
    emit_rdata      = 32'h0;
    emit_pc         = 32'h0;
    emit_compressed = 1'b0;
    consume         = 1'b1;
    if (match_resid) begin
      emit_valid      = 1'b1;
      emit_rdata      = {16'h0, slot_q.resid};
      emit_pc         = slot_q.rpc;
      emit_compressed = 1'b1;
      consume         = 1'b0;
      slot_d.state    = EMPTY;
    end else if (match_partial) begin
      emit_valid   = 1'b1;
      emit_rdata   = {lo_hw, slot_q.resid};
      emit_pc      = slot_q.rpc;
      slot_d.resid = hi_hw;
      slot_d.rpc   = hi_pc;
      slot_d.state = is_compressed(hi_hw) ? RESID_C : PARTIAL;
    end else if (!fetch_addr[1]) begin
      emit_valid = 1'b1;
      emit_pc    = word_pc;
      if (!is_compressed(lo_hw)) begin
        emit_rdata   = fetch_rdata;
        slot_d.state = EMPTY;
      end else begin
        emit_rdata      = {16'h0, lo_hw};
        emit_compressed = 1'b1;
        slot_d.resid    = hi_hw;
        slot_d.rpc      = hi_pc;
        slot_d.state    = is_compressed(hi_hw) ? RESID_C : PARTIAL;
      end
    end else begin
      if (is_compressed(hi_hw)) begin
        emit_valid      = 1'b1;
        emit_rdata      = {16'h0, hi_hw};
        emit_pc         = hi_pc;
        emit_compressed = 1'b1;
        slot_d.state    = EMPTY;
      end else begin
        slot_d.resid = hi_hw;
        slot_d.rpc   = hi_pc;
        slot_d.state = PARTIAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (flush) begin
      slot_q <= '0;
    end else if (sel) begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/riscv_mt_aligner.sv
// Multithreaded instruction aligner: per-hart slots, hart muxing and a one-entry output
// register. Define RISCV_MT_ALIGNER_PERF_EN to add per-hart compressed-instruction counters.
import riscv_defines::*;

module riscv_mt_aligner (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid_i,
  input  logic [31:0]                  fetch_rdata_i,
  input  logic [31:0]                  fetch_addr_i,
  input  logic [THREAD_ADDR_WIDTH-1:0] fetch_hart_i,
  output logic                         fetch_ready_o,
  output logic                         instr_valid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic [31:0]                  instr_pc_o,
  output logic [THREAD_ADDR_WIDTH-1:0] instr_hart_o,
  output logic                         instr_compressed_o,
  input  logic                         instr_ready_i,
  input  logic                         flush_i,
  input  logic [THREAD_ADDR_WIDTH-1:0] flush_hart_i
`ifdef RISCV_MT_ALIGNER_PERF_EN
  ,
  output logic [15:0]                  perf_cmp_cnt_o [NUM_THREADS]
`endif
);

  // Handshakes: a fetch word moves when fetch_valid_i & fetch_ready_o; an instruction
  // moves when instr_valid_o & instr_ready_i. The output register refills in the same
  // cycle it is drained, giving one instruction per cycle back to back.
  logic                   can_load;
  logic                   flush_hit;
  logic                   load_valid;
  logic [NUM_THREADS-1:0] sel;
  logic [NUM_THREADS-1:0] flush_vec;
  logic                   emit_valid      [NUM_THREADS];
  logic [31:0]            emit_rdata      [NUM_THREADS];
  logic [31:0]            emit_pc         [NUM_THREADS];
  logic                   emit_compressed [NUM_THREADS];
  logic                   emit_consume    [NUM_THREADS];
  logic                   unused_addr_bit0;

  assign unused_addr_bit0 = fetch_addr_i[0];
  assign can_load  = !instr_valid_o || instr_ready_i;
  assign flush_hit = flush_i && fetch_valid_i && (flush_hart_i == fetch_hart_i);

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_slot
    localparam logic [THREAD_ADDR_WIDTH-1:0] HART = THREAD_ADDR_WIDTH'(i);

    assign sel[i]       = fetch_valid_i && !flush_hit && can_load && (fetch_hart_i == HART);
    assign flush_vec[i] = flush_i && (flush_hart_i == HART);

    riscv_mt_aligner_slot u_slot (
      .clk             (clk),
      .rst_n           (rst_n),
      .sel             (sel[i]),
      .flush           (flush_vec[i]),
      .fetch_rdata     (fetch_rdata_i),
      .fetch_addr      (fetch_addr_i[31:1]),
      .emit_valid      (emit_valid[i]),
      .emit_rdata      (emit_rdata[i]),
      .emit_pc         (emit_pc[i]),
      .emit_compressed (emit_compressed[i]),
      .consume         (emit_consume[i])
    );
  end

  // A flushed word is swallowed even while the output register is stalled.
  assign fetch_ready_o = fetch_valid_i &&
                         (flush_hit || (can_load && emit_consume[fetch_hart_i]));
  assign load_valid    = fetch_valid_i && !flush_hit && emit_valid[fetch_hart_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid_o      <= 1'b0;
      instr_rdata_o      <= 32'h0;
      instr_pc_o         <= 32'h0;
      instr_hart_o       <= '0;
      instr_compressed_o <= 1'b0;
    end else if (can_load) begin
      instr_valid_o <= load_valid;
      if (load_valid) begin
        instr_rdata_o      <= emit_rdata[fetch_hart_i];
        instr_pc_o         <= emit_pc[fetch_hart_i];
        instr_hart_o       <= fetch_hart_i;
        instr_compressed_o <= emit_compressed[fetch_hart_i];
      end
    end else if (flush_i && (flush_hart_i == instr_hart_o)) begin
      instr_valid_o <= 1'b0;
    end
  end

`ifdef RISCV_MT_ALIGNER_PERF_EN
  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_perf
    localparam logic [THREAD_ADDR_WIDTH-1:0] HART = THREAD_ADDR_WIDTH'(i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        perf_cmp_cnt_o[i] <= 16'h0;
      end else if (flush_vec[i]) begin
        perf_cmp_cnt_o[i] <= 16'h0;
      end else if (instr_valid_o && instr_ready_i && instr_compressed_o &&
                   (instr_hart_o == HART) && (perf_cmp_cnt_o[i] != 16'hFFFF)) begin
        perf_cmp_cnt_o[i] <= perf_cmp_cnt_o[i] + 16'd1;
      end
    end
  end
`else
  // Counters are not built; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_riscv_mt_aligner.sv
// Bench for riscv_mt_aligner: directed scenarios plus randomized multi-hart traffic
// checked against a halfword-stream reference model.
module tb_riscv_mt_aligner;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_addr_i;
  logic [1:0]  fetch_hart_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic [1:0]  instr_hart_o;
  logic        instr_compressed_o;
  logic        instr_ready_i;
  logic        flush_i;
  logic [1:0]  flush_hart_i;
`ifdef RISCV_MT_ALIGNER_PERF_EN
  logic [15:0] perf_cmp_cnt_o [NT];
`endif

  riscv_mt_aligner dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_rdata_i      (fetch_rdata_i),
    .fetch_addr_i       (fetch_addr_i),
    .fetch_hart_i       (fetch_hart_i),
    .fetch_ready_o      (fetch_ready_o),
    .instr_valid_o      (instr_valid_o),
    .instr_rdata_o      (instr_rdata_o),
    .instr_pc_o         (instr_pc_o),
    .instr_hart_o       (instr_hart_o),
    .instr_compressed_o (instr_compressed_o),
    .instr_ready_i      (instr_ready_i),
    .flush_i            (flush_i),
`ifdef RISCV_MT_ALIGNER_PERF_EN
    .perf_cmp_cnt_o     (perf_cmp_cnt_o),
`endif
    .flush_hart_i       (flush_hart_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model state and scoreboard ----------------
  logic        pend_v  [NT];
  logic [15:0] pend_hw [NT];
  logic [31:0] pend_pc [NT];
  logic        m_valid;
  logic [31:0] m_rdata;
  logic [31:0] m_pc;
  logic [1:0]  m_hart;
  logic        m_comp;
  logic [31:0] exp_q [$];
  logic        smp_ready;
  logic        pred_ready;
  logic [31:0] nxt_addr [NT];
  logic [31:0] nxt_data [NT];
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      pend_v[i]  = 1'b0;
      pend_hw[i] = 16'h0;
      pend_pc[i] = 32'h0;
    end
    m_valid = 1'b0;
    m_rdata = 32'h0;
    m_pc    = 32'h0;
    m_hart  = 2'd0;
    m_comp  = 1'b0;
    exp_q.delete();
  endtask

  // The hart sees a stream of halfwords: its leftover (if it continues contiguously)
  // followed by the addressed halfwords of the word. The first instruction of that
  // stream is emitted; a lone leftover instruction does not use up the word.
  task automatic model_parse(output logic ev, output logic [31:0] ed, output logic [31:0] ep,
                             output logic ec, output logic cons, output logic np_v,
                             output logic [15:0] np_hw, output logic [31:0] np_pc);
    logic [15:0] shw [3];
    logic [31:0] spc [3];
    logic [31:0] wpc;
    logic [31:0] first_pc;
    logic        from_pend;
    int          n;
    int          used;
    int          h;
    h        = int'(fetch_hart_i);
    shw      = '{16'h0, 16'h0, 16'h0};
    spc      = '{32'h0, 32'h0, 32'h0};
    wpc      = {fetch_addr_i[31:2], 2'b00};
    first_pc = fetch_addr_i[1] ? wpc + 32'd2 : wpc;
    n        = 0;
    from_pend = pend_v[h] && ((pend_pc[h] + 32'd2) == first_pc);
    if (from_pend) begin
      shw[0] = pend_hw[h];
      spc[0] = pend_pc[h];
      n = 1;
    end
    if (!fetch_addr_i[1]) begin
      shw[n] = fetch_rdata_i[15:0];
      spc[n] = wpc;
      n++;
    end
    shw[n] = fetch_rdata_i[31:16];
    spc[n] = wpc + 32'd2;
    n++;
    ev = 1'b0; ed = 32'h0; ep = spc[0]; ec = 1'b0; used = 0;
    if (shw[0][1:0] != 2'b11) begin
      ev = 1'b1; ed = {16'h0, shw[0]}; ec = 1'b1; used = 1;
    end else if (n >= 2) begin
      ev = 1'b1; ed = {shw[1], shw[0]}; used = 2;
    end
    if (from_pend && used == 1) begin
      cons = 1'b0; np_v = 1'b0; np_hw = 16'h0; np_pc = 32'h0;
    end else begin
      cons  = 1'b1;
      np_v  = (n > used);
      np_hw = shw[used];
      np_pc = spc[used];
    end
  endtask

  // One clock: compare DUT against model at negedge, advance model, then let the DUT clock.
  task automatic cycle();
    logic        ev, ec, cons, npv, can_load, flush_hit;
    logic [31:0] ed, ep, nppc;
    logic [15:0] nphw;
    int          h;
    @(negedge clk);
    h = int'(fetch_hart_i);
    model_parse(ev, ed, ep, ec, cons, npv, nphw, nppc);
    can_load   = !m_valid || instr_ready_i;
    flush_hit  = flush_i && fetch_valid_i && (flush_hart_i == fetch_hart_i);
    pred_ready = fetch_valid_i && (flush_hit || (can_load && cons));
    smp_ready  = fetch_ready_o;
    check("fetch_ready", 32'(fetch_ready_o), 32'(pred_ready));
    check("instr_valid", 32'(instr_valid_o), 32'(m_valid));
    if (m_valid) begin
      check("instr_rdata", instr_rdata_o, m_rdata);
      check("instr_pc", instr_pc_o, m_pc);
      check("instr_hart", 32'(instr_hart_o), 32'(m_hart));
      check("instr_compressed", 32'(instr_compressed_o), 32'(m_comp));
    end
    if (instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL transfer: got 0x%08h expected no instruction", instr_rdata_o);
      end else begin
        check("transfer", instr_rdata_o, exp_q.pop_front());
      end
    end
    if (flush_i) pend_v[int'(flush_hart_i)] = 1'b0;
    if (fetch_valid_i && !flush_hit && can_load) begin
      pend_v[h]  = npv;
      pend_hw[h] = nphw;
      pend_pc[h] = nppc;
    end
    if (can_load) begin
      m_valid = fetch_valid_i && !flush_hit && ev;
      if (m_valid) begin
        m_rdata = ed;
        m_pc    = ep;
        m_hart  = fetch_hart_i;
        m_comp  = ec;
        exp_q.push_back(ed);
      end
    end else if (flush_i && (m_hart == flush_hart_i)) begin
      m_valid = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] h, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic fl,
                       input logic [1:0] fh);
    fetch_valid_i = v;
    fetch_hart_i  = h;
    fetch_addr_i  = a;
    fetch_rdata_i = d;
    instr_ready_i = rdy;
    flush_i       = fl;
    flush_hart_i  = fh;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic expect_out(input string name, input logic [31:0] d, input logic [31:0] pc,
                            input logic comp);
    check({name, "_valid"}, 32'(instr_valid_o), 32'd1);
    check({name, "_rdata"}, instr_rdata_o, d);
    check({name, "_pc"}, instr_pc_o, pc);
    check({name, "_comp"}, 32'(instr_compressed_o), 32'(comp));
  endtask

  function automatic logic [31:0] gen_data();
    logic [31:0] d;
    d = $urandom;
    d[1:0]   = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 2));
    d[17:16] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 2));
    return d;
  endfunction

  task automatic new_target(input int h);
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
    else a = 32'h0000_1000 + 32'($urandom_range(0, 63)) * 32'd4;
    if ($urandom_range(0, 3) == 0) a[1] = 1'b1;
    nxt_addr[h] = a;
    nxt_data[h] = gen_data();
  endtask

  task automatic advance(input int h);
    if ($urandom_range(0, 9) == 0) new_target(h);
    else begin
      nxt_addr[h] = {nxt_addr[h][31:2] + 30'd1, 2'b00};
      nxt_data[h] = gen_data();
    end
  endtask

  task automatic random_phase(input int cycles);
    logic       v, rdy, fl;
    logic [1:0] h, fh;
    for (int c = 0; c < cycles; c++) begin
      h   = 2'($urandom_range(0, 3));
      v   = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 19) == 0);
      fh  = 2'($urandom_range(0, 3));
      drive(v, h, nxt_addr[h], nxt_data[h], rdy, fl, fh);
      cycle();
      if (fl) new_target(int'(fh));
      if (v && pred_ready && !(fl && fh == h)) advance(int'(h));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    idle();
    for (int i = 0; i < NT; i++) new_target(i);
    #12;
    check("reset_valid", 32'(instr_valid_o), 32'd0);
    check("reset_rdata", instr_rdata_o, 32'h0);
    check("reset_pc", instr_pc_o, 32'h0);
    check("reset_hart", 32'(instr_hart_o), 32'd0);
    check("reset_comp", 32'(instr_compressed_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 32-bit instruction, one cycle latency
    drive(1'b1, 2'd0, 32'h100, 32'h0001_0413, 1'b1, 1'b0, 2'd0);
    cycle();
    check("t1_ready", 32'(smp_ready), 32'd1);
    expect_out("t1", 32'h0001_0413, 32'h100, 1'b0);
    check("t1_hart", 32'(instr_hart_o), 32'd0);

    // two compressed halfwords; the second is emitted while the next word waits
    drive(1'b1, 2'd1, 32'h200, 32'h4501_4505, 1'b1, 1'b0, 2'd0);
    cycle();
    expect_out("t2a", 32'h0000_4505, 32'h200, 1'b1);
    check("t2a_hart", 32'(instr_hart_o), 32'd1);
    drive(1'b1, 2'd1, 32'h204, 32'h0001_0413, 1'b1, 1'b0, 2'd0);
    cycle();
    check("t2b_ready", 32'(smp_ready), 32'd0);
    expect_out("t2b", 32'h0000_4501, 32'h202, 1'b1);
    check("t2b_model_pc", m_pc, 32'h202);
    cycle();
    check("t2c_ready", 32'(smp_ready), 32'd1);
    expect_out("t2c", 32'h0001_0413, 32'h204, 1'b0);
    idle();
    cycle();

    // 32-bit instruction straddling two words
    drive(1'b1, 2'd2, 32'h302, 32'h0413_ABCD, 1'b1, 1'b0, 2'd0);
    cycle();
    check("t3a_valid", 32'(instr_valid_o), 32'd0);
    drive(1'b1, 2'd2, 32'h304, 32'h1234_0001, 1'b1, 1'b0, 2'd0);
    cycle();
    expect_out("t3b", 32'h0001_0413, 32'h302, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 2'd2);
    cycle();

    // straddle across the top of the address space
    drive(1'b1, 2'd1, 32'hFFFF_FFFE, 32'h0413_0000, 1'b1, 1'b0, 2'd0);
    cycle();
    drive(1'b1, 2'd1, 32'h0, 32'h0000_0001, 1'b1, 1'b0, 2'd0);
    cycle();
    expect_out("wrap", 32'h0001_0413, 32'hFFFF_FFFE, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 2'd1);
    cycle();

    // two harts interleaved, both mid-instruction
    drive(1'b1, 2'd0, 32'h502, 32'h0413_0000, 1'b1, 1'b0, 2'd0); cycle();
    drive(1'b1, 2'd1, 32'h602, 32'h0613_0000, 1'b1, 1'b0, 2'd0); cycle();
    drive(1'b1, 2'd0, 32'h504, 32'h0513_0001, 1'b1, 1'b0, 2'd0); cycle();
    expect_out("t4a", 32'h0001_0413, 32'h502, 1'b0);
    drive(1'b1, 2'd1, 32'h604, 32'h0713_0002, 1'b1, 1'b0, 2'd0); cycle();
    expect_out("t4b", 32'h0002_0613, 32'h602, 1'b0);
    drive(1'b1, 2'd0, 32'h508, 32'h0000_0003, 1'b1, 1'b0, 2'd0); cycle();
    expect_out("t4c", 32'h0003_0513, 32'h506, 1'b0);
    drive(1'b1, 2'd1, 32'h608, 32'h0000_0004, 1'b1, 1'b0, 2'd0); cycle();
    expect_out("t4d", 32'h0004_0713, 32'h606, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 2'd0); cycle();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 2'd1); cycle();

    // flush and fetch of the same hart in one cycle
    drive(1'b1, 2'd3, 32'h702, 32'h0413_0000, 1'b1, 1'b0, 2'd0); cycle();
    drive(1'b1, 2'd3, 32'h704, 32'h0000_0001, 1'b1, 1'b1, 2'd3); cycle();
    check("t5_flush_ready", 32'(smp_ready), 32'd1);
    check("t5_flush_valid", 32'(instr_valid_o), 32'd0);
    drive(1'b1, 2'd3, 32'h400, 32'h0001_0413, 1'b1, 1'b0, 2'd0); cycle();
    expect_out("t5", 32'h0001_0413, 32'h400, 1'b0);
    idle();
    cycle();

    // downstream stall for three cycles
    drive(1'b1, 2'd0, 32'h800, 32'h4501_4505, 1'b0, 1'b0, 2'd0); cycle();
    expect_out("t6a", 32'h0000_4505, 32'h800, 1'b1);
    drive(1'b1, 2'd0, 32'h804, 32'h0001_0413, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_stall_ready", 32'(smp_ready), 32'd0);
      expect_out("t6_stall", 32'h0000_4505, 32'h800, 1'b1);
    end
    drive(1'b1, 2'd0, 32'h804, 32'h0001_0413, 1'b1, 1'b0, 2'd0); cycle();
    check("t6b_ready", 32'(smp_ready), 32'd0);
    expect_out("t6b", 32'h0000_4501, 32'h802, 1'b1);
    cycle();
    check("t6c_ready", 32'(smp_ready), 32'd1);
    expect_out("t6c", 32'h0001_0413, 32'h804, 1'b0);
    idle();
    cycle();

    random_phase(3000);

    // reset in the middle of traffic
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(instr_valid_o), 32'd0);
    check("midreset_rdata", instr_rdata_o, 32'h0);
    model_reset();
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;

    random_phase(600);

    idle();
    repeat (3) cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
